prog_sequencer: RTL and testbench

//  Launch controller sitting directly upstream of the core datapath inside TopLevel.

---
 rtl/prog_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_prog_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - launch controller: Start/Ack handshake to PC load plus run window
//
// Sequences programs P1..P<NUM_PROGS> on successive launches (rising edges of Start).
// Each launch gives a one-cycle PcLoad with the program base address. A run window
// (CoreRun) follows until CoreHalt. Ack is then held until the next launch.
// Optional watchdog: define PROG_SEQ_TIMEOUT_EN to end RUN after MAX_CYCLES cycles.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high
//   Start      in   launch request level; a launch is its rising edge
//   CoreHalt   in   core decoded halt/done this cycle (ignored outside RUN)
//   PcLoad     out  one-cycle strobe, core PC <= PcLoadAddr
//   PcLoadAddr out  base address of the program being launched
//   CoreRun    out  core may advance PC / commit state
//   Ack        out  program finished, held until next launch
//   ProgSel    out  index of current/last program (0 = P1)
//   CycleCount out  RUN cycles of current/last program, saturating
//   Timeout    out  last program ended by watchdog (0 without PROG_SEQ_TIMEOUT_EN)
module prog_sequencer #(
    parameter int              PC_W       = 10,
    parameter int              CYC_W      = 16,
    parameter int              NUM_PROGS  = 3,
    parameter logic [PC_W-1:0] P1_BASE    = 'd0,
    parameter logic [PC_W-1:0] P2_BASE    = 'd256,
    parameter logic [PC_W-1:0] P3_BASE    = 'd512,
    parameter logic [PC_W-1:0] P4_BASE    = 'd768,
    parameter int              MAX_CYCLES = 'd20000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             CoreHalt,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcLoadAddr,
    output logic             CoreRun,
    output logic             Ack,
    output logic [1:0]       ProgSel,
    output logic [CYC_W-1:0] CycleCount,
    output logic             Timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_SEL = 2'(NUM_PROGS - 1);

    state_t           state_q, state_d;
    logic             start_q;
    logic             pc_load_q, pc_load_d;
    logic [PC_W-1:0]  pc_addr_q, pc_addr_d;
    logic             core_run_q, core_run_d;
    logic             ack_q, ack_d;
    logic [1:0]       prog_sel_q, prog_sel_d;
    logic [1:0]       next_sel_q, next_sel_d;
    logic             started_q, started_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic             launch;
    logic [1:0]       launch_sel;

`ifdef PROG_SEQ_TIMEOUT_EN
    logic             timeout_q, timeout_d;
`endif

    function automatic logic [PC_W-1:0] base_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return P1_BASE;
            2'd1:    return P2_BASE;
            2'd2:    return P3_BASE;
            default: return P4_BASE;
        endcase
    endfunction

    assign launch = Start & ~start_q;

    // ProgSel keeps naming the finished program while Ack is high, so the index
    // for a new launch is derived here; the very first launch after reset uses 0.
    assign launch_sel = !started_q               ? 2'd0 :
                        (prog_sel_q == LAST_SEL) ? 2'd0 :
                                                   prog_sel_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        pc_load_d  = 1'b0;
        pc_addr_d  = pc_addr_q;
        core_run_d = 1'b0;
        ack_d      = ack_q;
        prog_sel_d = prog_sel_q;
        next_sel_d = next_sel_q;
        started_d  = started_q;
        cycle_d    = cycle_q;
`ifdef PROG_SEQ_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    state_d    = S_LOAD;
                    pc_load_d  = 1'b1;
                    pc_addr_d  = base_of(launch_sel);
                    next_sel_d = launch_sel;
                    cycle_d    = '0;
                    ack_d      = 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                state_d    = S_RUN;
                core_run_d = 1'b1;
                prog_sel_d = next_sel_q;
                started_d  = 1'b1;
            end
            S_RUN: begin
                // The halt cycle itself is counted.
                cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
                if (CoreHalt) begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
`ifdef PROG_SEQ_TIMEOUT_EN
                end else if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
                    state_d   = S_DONE;
                    ack_d     = 1'b1;
                    timeout_d = 1'b1;
`endif
                end else begin
                    core_run_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            pc_load_q  <= 1'b0;
            pc_addr_q  <= '0;
            core_run_q <= 1'b0;
            ack_q      <= 1'b0;
            prog_sel_q <= 2'd0;
            next_sel_q <= 2'd0;
            started_q  <= 1'b0;
            cycle_q    <= '0;
`ifdef PROG_SEQ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= Start;
            pc_load_q  <= pc_load_d;
            pc_addr_q  <= pc_addr_d;
            core_run_q <= core_run_d;
            ack_q      <= ack_d;
            prog_sel_q <= prog_sel_d;
            next_sel_q <= next_sel_d;
            started_q  <= started_d;
            cycle_q    <= cycle_d;
`ifdef PROG_SEQ_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign PcLoad     = pc_load_q;
    assign PcLoadAddr = pc_addr_q;
    assign CoreRun    = core_run_q;
    assign Ack        = ack_q;
    assign ProgSel    = prog_sel_q;
    assign CycleCount = cycle_q;

`ifdef PROG_SEQ_TIMEOUT_EN
    assign Timeout = timeout_q;
`else
    // Watchdog limit has no effect in this build.
    logic unused_max_cycles;
    assign unused_max_cycles = (MAX_CYCLES == 0);
    assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - scoreboard bench for prog_sequencer
module tb_prog_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        CoreHalt;
    logic        PcLoad;
    logic [9:0]  PcLoadAddr;
    logic        CoreRun;
    logic        Ack;
    logic [1:0]  ProgSel;
    logic [15:0] CycleCount;
    logic        Timeout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit is_ack;
        int addr;
        int count;
        int sel;
        int tmo;
    } exp_t;

    exp_t exp_q[$];
    logic ack_prev = 1'b0;

    prog_sequencer #(
        .MAX_CYCLES(16)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .CoreHalt  (CoreHalt),
        .PcLoad    (PcLoad),
        .PcLoadAddr(PcLoadAddr),
        .CoreRun   (CoreRun),
        .Ack       (Ack),
        .ProgSel   (ProgSel),
        .CycleCount(CycleCount),
        .Timeout   (Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Monitor: every PcLoad strobe and every rising Ack must match the next expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            if (PcLoad) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pcload", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_load", 0, int'(e.is_ack));
                    chk("pc_load_addr", int'(PcLoadAddr), e.addr);
                end
            end
            if (Ack && !ack_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_ack", 1, int'(e.is_ack));
                    chk("cycle_count", int'(CycleCount), e.count);
                    chk("prog_sel", int'(ProgSel), e.sel);
                    chk("timeout", int'(Timeout), e.tmo);
                end
            end
        end
        ack_prev = Ack;
    end

    task automatic push_load(input int addr);
        exp_q.push_back('{is_ack: 1'b0, addr: addr, count: 0, sel: 0, tmo: 0});
    endtask

    task automatic push_ack(input int count, input int sel, input int tmo);
        exp_q.push_back('{is_ack: 1'b1, addr: 0, count: count, sel: sel, tmo: tmo});
    endtask

    // Launch, then halt during RUN cycle 'cycles' (1-based).
    task automatic run_prog(input int addr, input int sel, input int cycles);
        push_load(addr);
        push_ack(cycles, sel, 0);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        chk("core_run_in_load", int'(CoreRun), 0);
        tick(1);
        chk("core_run_first", int'(CoreRun), 1);
        tick(cycles - 1);
        CoreHalt = 1'b1;
        tick(1);
        CoreHalt = 1'b0;
        chk("core_run_done", int'(CoreRun), 0);
        chk("ack_level", int'(Ack), 1);
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        CoreHalt = 1'b0;

        // Reset state
        tick(2);
        chk("rst_ack", int'(Ack), 0);
        chk("rst_pcload", int'(PcLoad), 0);
        chk("rst_corerun", int'(CoreRun), 0);
        chk("rst_progsel", int'(ProgSel), 0);
        chk("rst_cycles", int'(CycleCount), 0);
        chk("rst_timeout", int'(Timeout), 0);
        Reset = 1'b0;
        tick(1);
        chk("idle_corerun", int'(CoreRun), 0);
        chk("idle_ack", int'(Ack), 0);

        // Single program, halt on 7th RUN cycle; halt in DONE is ignored
        run_prog(0, 0, 7);
        CoreHalt = 1'b1;
        tick(1);
        CoreHalt = 1'b0;
        chk("done_halt_ack", int'(Ack), 1);
        chk("done_halt_corerun", int'(CoreRun), 0);
        chk("done_halt_cycles", int'(CycleCount), 7);

        // Fresh sequence of four rounds with wrap
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(1);
        run_prog(0,   0, 3);
        run_prog(256, 1, 1);
        run_prog(512, 2, 10);
        run_prog(0,   0, 2);

        // Start held high for 50 cycles, then an extra pulse during RUN
        push_load(256);
        push_ack(55, 1, 0);
        Start = 1'b1;
        tick(2);
        chk("held_corerun", int'(CoreRun), 1);
        tick(48);
        Start = 1'b0;
        tick(2);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        chk("pulse_in_run_ack", int'(Ack), 0);
        chk("pulse_in_run_corerun", int'(CoreRun), 1);
        tick(3);
        CoreHalt = 1'b1;
        tick(1);
        CoreHalt = 1'b0;
        chk("held_ack", int'(Ack), 1);

        // Reset mid-RUN at CycleCount 40
        push_load(512);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(41);
        chk("midrun_cycles", int'(CycleCount), 40);
        chk("midrun_progsel", int'(ProgSel), 2);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("abort_corerun", int'(CoreRun), 0);
        chk("abort_cycles", int'(CycleCount), 0);
        chk("abort_progsel", int'(ProgSel), 0);
        chk("abort_ack", int'(Ack), 0);
        tick(1);
        run_prog(0, 0, 2);

        // Watchdog
`ifdef PROG_SEQ_TIMEOUT_EN
        push_load(256);
        push_ack(16, 1, 1);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        for (int i = 0; i < 40 && !Ack; i++) tick(1);
        chk("wd_ack", int'(Ack), 1);
        chk("wd_timeout", int'(Timeout), 1);
        chk("wd_corerun", int'(CoreRun), 0);
`else
        push_load(256);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(100);
        chk("nowd_corerun", int'(CoreRun), 1);
        chk("nowd_ack", int'(Ack), 0);
        chk("nowd_timeout", int'(Timeout), 0);
        chk("nowd_cycles", int'(CycleCount), 99);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
`endif

        tick(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
